mips_control_fsm_v2: RTL

//  Parametrised multicycle control FSM; successor to the fixed-width controller. Adds memory wait-state

---
 rtl/mips_control_fsm_v2.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_control_fsm_v2.sv
// Multicycle MIPS-style control FSM. Memory handshakes have a wait timeout, IN/OUT handshakes block,
// and faults are sticky. Datapath controls are decoded from the registered state.
module mips_control_fsm_v2 #(
  parameter int OPCODE_W   = 5,
  parameter int ALUOP_W    = 3,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  input  logic                InValid,
  input  logic                OutReady,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                SrcA,
  output logic [1:0]          SrcB,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          RegDest,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                MemSrc,
  output logic [1:0]          PCSrc,
  output logic                BranchEn,
  output logic                BranchCond,
  output logic                OutputWrite,
  output logic [1:0]          Fault,
  output logic [4:0]          State
);

  typedef enum logic [4:0] {
    S_RST = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_REXEC = 5'd3, S_RWB = 5'd4,
    S_MADDR = 5'd5, S_LW = 5'd6, S_LWB = 5'd7, S_SW = 5'd8, S_IMM = 5'd9, S_IWB = 5'd10,
    S_JAL = 5'd11, S_JR = 5'd12, S_J = 5'd13, S_BEQ = 5'd14, S_BNE = 5'd15,
    S_IN = 5'd16, S_OUT = 5'd17, S_FAULT = 5'd18
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       fault;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             op_hi_zero;
  logic [4:0]       op5;

  assign op5         = Opcode[4:0];
  assign op_hi_zero  = ((Opcode >> 5) == '0);
  assign timeout_hit = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT);
  assign cnt_inc     = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);

  // wait_cnt defaults to clear, so any entry into FETCH/LW/SW starts from zero
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_RST;
      wait_cnt <= '0;
      fault    <= 2'b00;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_RST:   state <= S_FETCH;
        S_FETCH, S_LW, S_SW: begin
          if (MemReady) begin
            if (state == S_FETCH)   state <= S_DECODE;
            else if (state == S_LW) state <= S_LWB;
            else                    state <= S_FETCH;
          end else if (timeout_hit) begin
            state <= S_FAULT;
            fault <= 2'b01;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        S_DECODE: begin
          if (!op_hi_zero) begin
            state <= S_FAULT;
            fault <= 2'b10;
          end else begin
            case (op5)
              5'h00, 5'h01, 5'h02, 5'h03: state <= S_REXEC;
              5'h04, 5'h05, 5'h06, 5'h07: state <= S_IMM;
              5'h08, 5'h09:               state <= S_MADDR;
              5'h0A:                      state <= S_JAL;
              5'h0B:                      state <= S_JR;
              5'h0C:                      state <= S_J;
              5'h0D:                      state <= S_BEQ;
              5'h0E:                      state <= S_BNE;
              5'h10:                      state <= S_IN;
              5'h11:                      state <= S_OUT;
              default: begin
                state <= S_FAULT;
                fault <= 2'b10;
              end
            endcase
          end
        end
        S_REXEC: state <= S_RWB;
        S_IMM:   state <= S_IWB;
        S_MADDR: state <= Opcode[0] ? S_SW : S_LW;
        S_RWB, S_LWB, S_IWB, S_JAL, S_JR, S_J, S_BEQ, S_BNE: state <= S_FETCH;
        S_IN:    if (InValid)  state <= S_FETCH;
        S_OUT:   if (OutReady) state <= S_FETCH;
        S_FAULT: state <= S_FAULT;
        default: begin
          state <= S_FAULT;
          fault <= 2'b10;
        end
      endcase
    end
  end

  always_comb begin
    ALUOp       = '0;
    SrcA        = 1'b0;
    SrcB        = 2'd0;
    MemtoReg    = 2'd0;
    RegDest     = 2'd0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    MemSrc      = 1'b0;
    PCSrc       = 2'd0;
    BranchEn    = 1'b0;
    BranchCond  = 1'b0;
    OutputWrite = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        SrcB    = 2'd1;
        ALUOp   = ALUOP_W'(3'b010);
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        SrcB  = 2'd3;
        ALUOp = ALUOP_W'(3'b010);
      end
      S_REXEC: begin
        SrcA  = 1'b1;
        ALUOp = ALUOP_W'({1'b1, Opcode[1:0]});
      end
      S_RWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
        RegDest  = 2'd1;
      end
      S_IMM: begin
        SrcA  = 1'b1;
        SrcB  = 2'd2;
        ALUOp = ALUOP_W'({1'b1, Opcode[1:0]});
      end
      S_IWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
      end
      S_MADDR: begin
        SrcA  = 1'b1;
        SrcB  = 2'd2;
        ALUOp = ALUOP_W'(3'b010);
      end
      S_LW: begin
        MemRead = 1'b1;
        MemSrc  = 1'b1;
      end
      S_LWB: RegWrite = 1'b1;
      S_SW: begin
        MemWrite = 1'b1;
        MemSrc   = 1'b1;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd3;
        RegDest  = 2'd2;
        PCWrite  = 1'b1;
        PCSrc    = 2'd1;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = 2'd2;
      end
      S_J: begin
        PCWrite = 1'b1;
        PCSrc   = 2'd1;
      end
      S_BEQ, S_BNE: begin
        SrcA       = 1'b1;
        ALUOp      = ALUOP_W'(3'b011);
        PCSrc      = 2'd3;
        BranchEn   = 1'b1;
        BranchCond = (state == S_BEQ);
      end
      S_IN: begin
        RegWrite = InValid;
        MemtoReg = 2'd2;
      end
      S_OUT: OutputWrite = 1'b1;
      default: ;
    endcase
  end

  assign Fault = fault;
  assign State = state;

endmodule
